// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: elastic pipeline stage register between two CPU stages.
// Carries a DATA_W payload and a CTRL_W control field across one boundary
// with a valid/ready handshake, back-pressure, synchronous flush and an
// optional second (skid) entry selected by SKID.
//
// Handshake: an entry moves across a port only in a cycle where both valid
// and ready are high at the rising edge of cpu_clk (in_fire / out_fire).
// Once out_valid is high, out_data/out_ctrl stay unchanged until out_fire
// or flush; valid never drops without a consuming edge or a flush/reset.
//
// Optional feature macro: PIPE_STAGE_STATS_EN enables the stall_cnt and
// bubble_cnt performance counters; when undefined both read as zero.
module mem_wb_pipe_stage #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [1:0]        dbg_state_o
);

    // EMPTY: nothing held; ONE: main entry valid (FULL when SKID=0);
    // TWO: main and skid entries both valid (SKID=1 only).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    assign out_valid   = (state_q != ST_EMPTY);
    // With a skid entry the upstream sees a registered ready; without one
    // the stage can refill in the same cycle it is drained.
    assign in_ready    = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

    // Control bits (rf_we etc.) must never leak out of a bubble; the payload
    // simply keeps its last value.
    assign out_data    = main_data_q;
    assign out_ctrl    = out_valid ? main_ctrl_q : '0;
    assign dbg_state_o = state_q;

    // Next-state, entry loading and registered ready computation.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire && (SKID != 0)) begin
                    // Downstream stalled after we already promised ready:
                    // park the new entry behind the held one.
                    state_d     = ST_TWO;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush squashes everything, including an entry accepted this cycle;
        // storage is left untouched so the squashed entry never shows up.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
        end

        in_ready_d = (state_d != ST_TWO);
    end

    // State and entry registers; reset discards all entries at once.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating increments: stall = held but not consumed, bubble = empty.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter registers; only reset clears them, flush does not.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = 32'h0;
    assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: a SKID=1 and a SKID=0 instance share one
// input stream; each has its own expected-entry queue and counter model.
module tb_mem_wb_pipe_stage;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;
    localparam int ENT_W  = DATA_W + CTRL_W;

    logic              cpu_clk = 1'b0;
    logic              cpu_rst;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;

    logic              in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DATA_W-1:0] out_data1, out_data0;
    logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
    logic [31:0]       stall_cnt1, bubble_cnt1, stall_cnt0, bubble_cnt0;
    logic [1:0]        dbg1, dbg0;

    mem_wb_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
        .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1), .dbg_state_o(dbg1)
    );

    mem_wb_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0), .dbg_state_o(dbg0)
    );

    // ---------------- clock / reset ----------------
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [ENT_W-1:0] exp_q1[$];
    logic [ENT_W-1:0] exp_q0[$];
    logic [31:0] stall_exp1 = 0, bubble_exp1 = 0, stall_exp0 = 0, bubble_exp0 = 0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just before a rising edge with the inputs for that edge stable.
    task automatic sb_step();
        bit v1, v0, acc1, acc0;
        v1   = (exp_q1.size() != 0);
        v0   = (exp_q0.size() != 0);
        acc1 = in_valid && (exp_q1.size() < 2);
        acc0 = in_valid && (!v0 || out_ready);

        chk("d1_out_valid", out_valid1, v1);
        chk("d1_in_ready", in_ready1, exp_q1.size() < 2);
        if (v1) begin
            chk("d1_out_data", out_data1, exp_q1[0][DATA_W-1:0]);
            chk("d1_out_ctrl", out_ctrl1, exp_q1[0][ENT_W-1:DATA_W]);
        end else begin
            chk("d1_bubble_ctrl", out_ctrl1, 0);
        end
        chk("d0_out_valid", out_valid0, v0);
        chk("d0_in_ready", in_ready0, !v0 || out_ready);
        if (v0) begin
            chk("d0_out_data", out_data0, exp_q0[0][DATA_W-1:0]);
            chk("d0_out_ctrl", out_ctrl0, exp_q0[0][ENT_W-1:DATA_W]);
        end else begin
            chk("d0_bubble_ctrl", out_ctrl0, 0);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("d1_stall_cnt", stall_cnt1, stall_exp1);
        chk("d1_bubble_cnt", bubble_cnt1, bubble_exp1);
        chk("d0_stall_cnt", stall_cnt0, stall_exp0);
        chk("d0_bubble_cnt", bubble_cnt0, bubble_exp0);
`else
        chk("d1_stall_cnt", stall_cnt1, 0);
        chk("d1_bubble_cnt", bubble_cnt1, 0);
        chk("d0_stall_cnt", stall_cnt0, 0);
        chk("d0_bubble_cnt", bubble_cnt0, 0);
`endif
        if (v1 && !out_ready) stall_exp1++;
        if (!v1) bubble_exp1++;
        if (v0 && !out_ready) stall_exp0++;
        if (!v0) bubble_exp0++;

        if (v1 && out_ready) void'(exp_q1.pop_front());
        if (v0 && out_ready) void'(exp_q0.pop_front());
        if (flush) begin
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            if (acc1) exp_q1.push_back({in_ctrl, in_data});
            if (acc0) exp_q0.push_back({in_ctrl, in_data});
        end
    endtask

    // ---------------- driver ----------------
    // Entered at a falling edge; leaves at the next falling edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic r, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = fl;
        #4;
        sb_step();
        @(negedge cpu_clk);
    endtask

    // ---------------- directed vector table (SKID=1 expectations) ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] c;
        logic       r;
        logic       fl;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
        logic [7:0] e_oc;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [7:0] c,
                                input logic r, input logic fl, input logic e_ov,
                                input logic [7:0] e_od, input logic e_ir, input logic [7:0] e_oc);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.r = r; t.fl = fl;
        t.e_ov = e_ov; t.e_od = e_od; t.e_ir = e_ir; t.e_oc = e_oc;
        return t;
    endfunction

    initial begin
        // stream 1..8 with out_ready=1: one-cycle latency, one per cycle
        for (int i = 0; i < 8; i++) begin
            tbl[i] = mk(1'b1, 8'(i + 1), 8'(8'h11 + i), 1'b1, 1'b0,
                        (i != 0), 8'(i), 1'b1, (i == 0) ? 8'h00 : 8'(8'h10 + i));
        end
        tbl[8]  = mk(0, 8'h00, 8'hFF, 1, 0,  1, 8'h08, 1, 8'h18);
        // three bubbles with in_ctrl=FF: out_ctrl must stay zero
        tbl[9]  = mk(0, 8'h00, 8'hFF, 1, 0,  0, 8'h08, 1, 8'h00);
        tbl[10] = mk(0, 8'h00, 8'hFF, 1, 0,  0, 8'h08, 1, 8'h00);
        tbl[11] = mk(0, 8'h00, 8'hFF, 1, 0,  0, 8'h08, 1, 8'h00);
        // skid: accept A, B while stalled; D refused; then drain
        tbl[12] = mk(1, 8'h0A, 8'h2A, 0, 0,  0, 8'h08, 1, 8'h00);
        tbl[13] = mk(1, 8'h0B, 8'h2B, 0, 0,  1, 8'h0A, 1, 8'h2A);
        tbl[14] = mk(1, 8'h0D, 8'h2D, 0, 0,  1, 8'h0A, 0, 8'h2A);
        tbl[15] = mk(0, 8'h00, 8'h00, 1, 0,  1, 8'h0A, 0, 8'h2A);
        tbl[16] = mk(0, 8'h00, 8'h00, 1, 0,  1, 8'h0B, 1, 8'h2B);
        tbl[17] = mk(0, 8'h00, 8'h00, 0, 0,  0, 8'h0B, 1, 8'h00);
        // flush while TWO, then flush with an accepted C that must be dropped
        tbl[18] = mk(1, 8'h0E, 8'h2E, 0, 0,  0, 8'h0B, 1, 8'h00);
        tbl[19] = mk(1, 8'h0F, 8'h2F, 0, 0,  1, 8'h0E, 1, 8'h2E);
        tbl[20] = mk(1, 8'h0C, 8'h2C, 0, 1,  1, 8'h0E, 0, 8'h2E);
        tbl[21] = mk(1, 8'h0C, 8'h2C, 0, 1,  0, 8'h0E, 1, 8'h00);
        tbl[22] = mk(0, 8'h00, 8'h00, 1, 0,  0, 8'h0E, 1, 8'h00);
        // out_fire coinciding with flush
        tbl[23] = mk(1, 8'h01, 8'h31, 0, 0,  0, 8'h0E, 1, 8'h00);
        tbl[24] = mk(0, 8'h00, 8'h00, 1, 1,  1, 8'h01, 1, 8'h31);
        tbl[25] = mk(0, 8'h00, 8'h00, 1, 0,  0, 8'h01, 1, 8'h00);
    end

    // ---------------- test sequence ----------------
    initial begin
        cpu_rst   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        @(negedge cpu_clk);

        // reset state
        chk("rst_d1_out_valid", out_valid1, 0);
        chk("rst_d1_out_data", out_data1, 0);
        chk("rst_d1_in_ready", in_ready1, 1);
        chk("rst_d1_state", dbg1, 0);
        chk("rst_d0_out_valid", out_valid0, 0);
        chk("rst_d0_in_ready", in_ready0, 1);
        cpu_rst = 1'b0;

        // directed table
        for (int i = 0; i < 26; i++) begin
            in_valid  = tbl[i].v;
            in_data   = {88'h0, tbl[i].d};
            in_ctrl   = tbl[i].c;
            out_ready = tbl[i].r;
            flush     = tbl[i].fl;
            #4;
            chk($sformatf("tbl%0d_out_valid", i), out_valid1, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i), out_data1, {88'h0, tbl[i].e_od});
            chk($sformatf("tbl%0d_in_ready", i), in_ready1, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_ctrl", i), out_ctrl1, tbl[i].e_oc);
            sb_step();
            @(negedge cpu_clk);
        end

        // continuous in_valid with out_ready toggling
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DATA_W'(100 + i), CTRL_W'(i), (i % 2) == 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("toggle_drain_d1", exp_q1.size(), 0);
        chk("toggle_drain_d0", exp_q0.size(), 0);

        // random traffic with occasional flush
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
                  CTRL_W'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("rand_drain_d1", exp_q1.size(), 0);
        chk("rand_drain_d0", exp_q0.size(), 0);

        // asynchronous reset in the middle of a stall
        cycle(1'b1, DATA_W'(8'h55), 8'h66, 1'b0, 1'b0);
        cycle(1'b1, DATA_W'(8'h56), 8'h67, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #2;
        cpu_rst = 1'b1;
        #1;
        chk("arst_d1_out_valid", out_valid1, 0);
        chk("arst_d1_out_ctrl", out_ctrl1, 0);
        chk("arst_d1_out_data", out_data1, 0);
        chk("arst_d1_in_ready", in_ready1, 1);
        chk("arst_d1_stall_cnt", stall_cnt1, 0);
        chk("arst_d1_bubble_cnt", bubble_cnt1, 0);
        chk("arst_d0_out_valid", out_valid0, 0);
        chk("arst_d0_out_data", out_data0, 0);
        chk("arst_d0_in_ready", in_ready0, 1);
        exp_q1.delete();
        exp_q0.delete();
        stall_exp1 = 0; bubble_exp1 = 0; stall_exp0 = 0; bubble_exp0 = 0;
        @(negedge cpu_clk);
        chk("arst_hold_d1_out_valid", out_valid1, 0);
        cpu_rst = 1'b0;

        // restart after reset
        for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(i + 1), CTRL_W'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 8'hFF, 1'b1, 1'b0);
        chk("final_drain_d1", exp_q1.size(), 0);
        chk("final_drain_d0", exp_q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
